// File: rtl/zero_preamble_parity_tx.sv
// zero_preamble_parity_tx: serial framer (zero preamble, data, parity, stop); ZERO_PRE_TX_LSB_FIRST_EN selects LSB-first data
module zero_preamble_parity_tx #(
  parameter int DATA_W  = 8,
  parameter int PRE_LEN = 2,
  parameter int ODD_PAR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_out,
  output logic              tx_active,
  output logic              done
);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4;
  localparam int MX = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int CW = $clog2(MX + 1);
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_shift;
  logic              par_q, par_d, tx_q, tx_d, act_q, act_d, done_q, done_d, nxt_bit;
`ifdef ZERO_PRE_TX_LSB_FIRST_EN
  assign nxt_bit  = sh_q[0];
  assign sh_shift = sh_q >> 1;
`else
  assign nxt_bit  = sh_q[DATA_W-1];
  assign sh_shift = sh_q << 1;
`endif
  assign in_ready  = (state_q == IDLE);
  assign tx_out    = tx_q;
  assign tx_active = act_q;
  assign done      = done_q;
  // tx_d is the bit that will be on the line while in state_d
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    act_d   = act_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = PRE;
        cnt_d   = '0;
        sh_d    = in_data;
        par_d   = ^in_data ^ ODD_PAR[0];
        tx_d    = 1'b0;
        act_d   = 1'b1;
      end
      PRE: if (cnt_q == CW'(PRE_LEN - 1)) begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = nxt_bit;
        sh_d    = sh_shift;
      end else cnt_d = cnt_q + 1'b1;
      DATA: if (cnt_q == CW'(DATA_W - 1)) begin
        state_d = PAR;
        cnt_d   = '0;
        tx_d    = par_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        tx_d  = nxt_bit;
        sh_d  = sh_shift;
      end
      PAR: begin
        state_d = STOP;
        tx_d    = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        act_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_zero_preamble_parity_tx.sv
// tb_zero_preamble_parity_tx: frame-level queue model plus literal frame patterns for even and odd parity builds
module tb_zero_preamble_parity_tx;
  localparam int DW = 8, PL = 2, FL = PL + DW + 2;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic rdy_e, tx_e, act_e, dn_e, rdy_o, tx_o, act_o, dn_o;
  int checks = 0, errors = 0;
  logic [3:0] cur = 4'b1100;
  logic armed = 1'b0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  zero_preamble_parity_tx #(.DATA_W(DW), .PRE_LEN(PL), .ODD_PAR(0)) u_even (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_e), .in_data(in_data),
    .tx_out(tx_e), .tx_active(act_e), .done(dn_e));
  zero_preamble_parity_tx #(.DATA_W(DW), .PRE_LEN(PL), .ODD_PAR(1)) u_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_o), .in_data(in_data),
    .tx_out(tx_o), .tx_active(act_o), .done(dn_o));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, a, e);
    end
  endtask

  // Model entries are {in_ready, tx_out, tx_active, done} per cycle of a frame
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur   <= 4'b1100;
      armed <= 1'b1;
    end else if (cur[3] && in_valid) begin
      q.delete();
      for (int i = 0; i < PL; i++) q.push_back(4'b0010);
      for (int k = 0; k < DW; k++)
`ifdef ZERO_PRE_TX_LSB_FIRST_EN
        q.push_back({1'b0, in_data[k], 2'b10});
`else
        q.push_back({1'b0, in_data[DW-1-k], 2'b10});
`endif
      q.push_back({1'b0, ($countones(in_data) % 2) == 1, 2'b10});
      q.push_back(4'b0111);
      cur <= q.pop_front();
    end else if (q.size() > 0) cur <= q.pop_front();
    else cur <= 4'b1100;
  end

  always @(negedge clk)
    if (armed) chk("model", {28'b0, rdy_e, tx_e, act_e, dn_e}, {28'b0, cur});

  task automatic idle_chk(input string nm);
    chk({nm, " idle_even"}, {28'b0, rdy_e, tx_e, act_e, dn_e}, 32'hc);
    chk({nm, " idle_odd"}, {28'b0, rdy_o, tx_o, act_o, dn_o}, 32'hc);
  endtask

  task automatic send(input logic [7:0] d, input logic [11:0] ev, input logic [11:0] ov, input string nm);
    logic [11:0] be, bo, dv, av;
    int nr;
    nr = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      be = {be[10:0], tx_e};
      bo = {bo[10:0], tx_o};
      dv = {dv[10:0], dn_e};
      av = {av[10:0], act_e};
      nr += rdy_e ? 0 : 1;
    end
    chk({nm, " bits_even"}, {20'b0, be}, {20'b0, ev});
    chk({nm, " bits_odd"}, {20'b0, bo}, {20'b0, ov});
    chk({nm, " done"}, {20'b0, dv}, 32'h1);
    chk({nm, " active"}, {20'b0, av}, 32'hfff);
    chk({nm, " ready_low"}, nr, FL);
    @(negedge clk);
    idle_chk(nm);
  endtask

  initial begin
    logic [24:0] se, so;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    send(8'hA5, 12'b001010010101, 12'b001010010111, "a5");
`ifndef ZERO_PRE_TX_LSB_FIRST_EN
    send(8'h07, 12'b000000011111, 12'b000000011101, "07");
    send(8'h01, 12'b000000000111, 12'b000000000101, "01");
`else
    send(8'h01, 12'b001000000011, 12'b001000000001, "01");
`endif
    send(8'h00, 12'b000000000001, 12'b000000000011, "00");
    // back-to-back with in_valid held high and in_data scrambled mid-frame
    in_valid = 1'b1;
    in_data  = 8'h3C;
    for (int i = 0; i < 2 * FL + 1; i++) begin
      @(negedge clk);
      se = {se[23:0], tx_e};
      so = {so[23:0], tx_o};
      in_data = (i == FL) ? 8'hFF : 8'($urandom);
    end
    in_valid = 1'b0;
    chk("b2b even", {7'b0, se}, {7'b0, 25'b000011110001_1_001111111101});
    chk("b2b odd", {7'b0, so}, {7'b0, 25'b000011110011_1_001111111111});
    @(negedge clk);
    idle_chk("b2b");
    // reset during the third data bit
    in_valid = 1'b1;
    in_data  = 8'h81;
    for (int i = 0; i < PL + 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_chk("abort");
    send(8'h81, 12'b001000000101, 12'b001000000111, "81");
    repeat (3000) begin
      @(negedge clk);
      rst      = ($urandom % 300) == 0;
      in_valid = ($urandom % 3) != 0;
      in_data  = 8'($urandom);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zero_preamble_parity_tx.md
Name: zero_preamble_parity_tx

Overview:
Serial frame transmitter that produces the bit stream the team's zero-preamble/parity detectors consume. It accepts a parallel word over a valid/ready handshake and shifts out one bit per clk in this order: a preamble of PRE_LEN zeros, DATA_W data bits, one parity bit, then one stop bit of 1. It sits upstream of the serial line as the sender for the pattern-recognizer FSMs.

Parameters:
DATA_W, 8, payload width in bits; must be at least 1.
PRE_LEN, 2, number of preamble zero bits; must be at least 1.
ODD_PAR, 0, 0 selects even parity and 1 selects odd parity, counted over data plus parity bit.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  in_data is offered.
in_ready  out  1  block can accept a word; high only in IDLE.
in_data  in  DATA_W  word to transmit.
tx_out  out  1  serial line; idles high.
tx_active  out  1  high while a frame (preamble through stop) is on tx_out.
done  out  1  one-cycle pulse coincident with the stop bit.

Behaviour:
- States: IDLE, PRE, DATA, PAR, STOP.
- Outputs tx_out, tx_active and done are registered. in_ready is decoded as (state == IDLE).
- Reset values, taking effect at the first posedge with rst=1:
  - state = IDLE, tx_out = 1, tx_active = 0, done = 0, in_ready = 1.
  - Bit counter and shift register = 0.
- Accept: at a posedge where in_valid && in_ready, in_data is latched into the shift register and parity is computed as XOR(in_data) ^ ODD_PAR.
  - Changes to in_data after acceptance have no effect.
- IDLE -> PRE on accept. The cycle after accept, tx_out = 0 and tx_active = 1.
- PRE: drives 0 for exactly PRE_LEN cycles, then -> DATA.
- DATA: DATA_W cycles, MSB first (default). The shift register shifts each cycle, then -> PAR.
- PAR: drives the parity bit for 1 cycle, then -> STOP.
- STOP: drives 1 for 1 cycle with done = 1 and tx_active = 1, then -> IDLE.
- In IDLE: tx_out = 1, tx_active = 0, done = 0.
- Frame length is PRE_LEN + DATA_W + 2 cycles. From the accept edge to in_ready high again is PRE_LEN + DATA_W + 3 edges.
- Counter is sized $clog2(max(PRE_LEN, DATA_W) + 1). It reloads to 0 on every state change and never wraps within a state.
- in_valid outside IDLE is ignored: no accept, and no pending-request storage.
- Back-to-back: with in_valid held high, the next word is accepted at the IDLE-cycle edge. Minimum gap between frames is therefore the stop bit plus one idle 1 (two consecutive 1s).
- rst mid-frame aborts the frame:
  - Next cycle: tx_out = 1, tx_active = 0, in_ready = 1.
  - No done pulse.
- rst has priority over a simultaneous accept.

Optional Feature:
Macro ZERO_PRE_TX_LSB_FIRST_EN.
- Defined: data bits are serialized LSB first. Preamble, parity and stop are unchanged.
- Undefined: MSB first.
- The parity value is identical in both modes.

Test Plan:
- Even parity frame (DATA_W=8, PRE_LEN=2, ODD_PAR=0): reset, then send 0xA5 -> tx_out = 0,0,1,0,1,0,0,1,0,1,0,1. done high only on the final 1. in_ready low for 12 cycles.
- Odd number of ones (same parameters): send 0x07 -> data 0,0,0,0,0,1,1,1 with parity bit 1.
- ODD_PAR=1: send 0xA5 -> parity bit 1.
- ODD_PAR=1: send 0x00 -> parity bit 1, preamble and data all 0.
- Back-to-back with in_valid stuck high: words 0x3C then 0xFF -> exactly two 1s (stop, idle) between frames.
  - Second frame parity = 0.
  - Toggling in_data mid-frame does not alter the bits sent.
- Reset mid-frame: assert rst for 1 cycle during the 3rd data bit of 0x81.
  - Next cycle: tx_out = 1, tx_active = 0, in_ready = 1, no done.
  - A following send of 0x81 transmits a complete, correct frame.
- With ZERO_PRE_TX_LSB_FIRST_EN defined: send 0x01 -> data bits 1,0,0,0,0,0,0,0 and parity 1 (even mode).
